// File: rtl/requantize_9bit_core.sv
// Requantizes SIZE packed signed 9-bit pixels to saturated int8 with a power-of-two scale and one output register.
// Optional macro REQUANTIZE_ROUND_EN selects round-half-up instead of floor for right shifts.
module requantize_9bit_core #(
  parameter int SHIFT = 1,
  parameter int SIZE  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [9*SIZE-1:0]   pixel_in,
  output logic [8*SIZE-1:0]   pixel_out
);

  localparam int ABS_SHIFT = (SHIFT < 0) ? -SHIFT : SHIFT;
  localparam int RB_SHIFT  = (ABS_SHIFT > 0) ? ABS_SHIFT - 1 : 0;
  localparam logic signed [17:0] SAT_MAX = 18'sd127;
  localparam logic signed [17:0] SAT_MIN = -18'sd128;

`ifdef REQUANTIZE_ROUND_EN
  // Half an output LSB is added ahead of the right shift, giving round-half-up.
  localparam logic signed [17:0] ROUND_BIAS = (SHIFT < 0) ? (18'sd1 <<< RB_SHIFT) : 18'sd0;
`else
  localparam logic signed [17:0] ROUND_BIAS = 18'sd0;
`endif

  logic [8*SIZE-1:0] requant_s;

  // Scales one lane; the 18-bit width holds the largest left shift without overflow.
  function automatic logic [7:0] requant_lane(input logic [8:0] px);
    logic signed [17:0] ext_s;
    logic signed [17:0] scaled_s;
    ext_s = $signed({{9{px[8]}}, px});
    if (SHIFT > 0) begin
      scaled_s = ext_s <<< ABS_SHIFT;
    end else if (SHIFT < 0) begin
      scaled_s = (ext_s + ROUND_BIAS) >>> ABS_SHIFT;
    end else begin
      scaled_s = ext_s;
    end
    if (scaled_s > SAT_MAX) begin
      requant_lane = 8'h7F;
    end else if (scaled_s < SAT_MIN) begin
      requant_lane = 8'h80;
    end else begin
      requant_lane = scaled_s[7:0];
    end
  endfunction

  // Per-lane combinational requantization.
  always_comb begin
    requant_s = {(8*SIZE){1'b0}};
    for (int k = 0; k < SIZE; k++) begin
      requant_s[8*k +: 8] = requant_lane(pixel_in[9*k +: 9]);
    end
  end

  // Output register; reset overrides the datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      pixel_out <= {(8*SIZE){1'b0}};
    end else begin
      pixel_out <= requant_s;
    end
  end

endmodule

// File: tb/tb_requantize_9bit_core.sv
// Scoreboard bench: three instances (SHIFT = +1, -1, 0) share one randomized input stream
// and are checked against an integer-arithmetic reference model.
module tb_requantize_9bit_core;

  localparam int SIZE = 4;

  logic              clock;
  logic              reset;
  logic [9*SIZE-1:0] pixel_in;
  logic [8*SIZE-1:0] out_p1;
  logic [8*SIZE-1:0] out_m1;
  logic [8*SIZE-1:0] out_z;

  typedef struct packed {
    logic [8*SIZE-1:0] exp_p1;
    logic [8*SIZE-1:0] exp_m1;
    logic [8*SIZE-1:0] exp_z;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  requantize_9bit_core #(.SHIFT(1), .SIZE(SIZE)) dut_p1 (
    .clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_out(out_p1));
  requantize_9bit_core #(.SHIFT(-1), .SIZE(SIZE)) dut_m1 (
    .clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_out(out_m1));
  requantize_9bit_core #(.SHIFT(0), .SIZE(SIZE)) dut_z (
    .clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_out(out_z));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: value * 2^s or floor(value / 2^|s|), then clamp to int8.
  function automatic logic [7:0] ref_lane(input logic [8:0] px, input int s);
    int v;
    int d;
    int q;
    v = int'($signed(px));
    if (s > 0) begin
      q = v * (1 << s);
    end else if (s < 0) begin
      d = 1 << (-s);
`ifdef REQUANTIZE_ROUND_EN
      v = v + d / 2;
`endif
      q = v / d;
      if ((v % d) != 0 && v < 0) q = q - 1;
    end else begin
      q = v;
    end
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return 8'(q);
  endfunction

  function automatic logic [8*SIZE-1:0] ref_vec(input logic [9*SIZE-1:0] vin, input int s);
    logic [8*SIZE-1:0] r;
    r = '0;
    for (int k = 0; k < SIZE; k++) r[8*k +: 8] = ref_lane(vin[9*k +: 9], s);
    return r;
  endfunction

  function automatic logic [9*SIZE-1:0] pack4(input int l3, input int l2, input int l1, input int l0);
    return {9'(l3), 9'(l2), 9'(l1), 9'(l0)};
  endfunction

  task automatic check(input string name, input logic [8*SIZE-1:0] act, input logic [8*SIZE-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [9*SIZE-1:0] vec);
    sb_entry_t e;
    @(negedge clock);
    reset    = rst;
    pixel_in = vec;
    if (rst) begin
      e = '0;
    end else begin
      e.exp_p1 = ref_vec(vec, 1);
      e.exp_m1 = ref_vec(vec, -1);
      e.exp_z  = ref_vec(vec, 0);
    end
    sb_q.push_back(e);
  endtask

  function automatic logic [9*SIZE-1:0] rand_vec();
    logic [9*SIZE-1:0] v;
    for (int k = 0; k < SIZE; k++) begin
      case ($urandom_range(0, 4))
        0: v[9*k +: 9] = 9'h0FF;
        1: v[9*k +: 9] = 9'h100;
        2: v[9*k +: 9] = 9'(int'($urandom_range(0, 8)) - 4);
        default: v[9*k +: 9] = 9'($urandom());
      endcase
    end
    return v;
  endfunction

  // Monitor: one result per clock once stimulus is in flight.
  always @(posedge clock) begin
    sb_entry_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("shift_p1", out_p1, e.exp_p1);
      check("shift_m1", out_m1, e.exp_m1);
      check("shift_0",  out_z,  e.exp_z);
    end
  end

  initial begin
    reset    = 1'b1;
    pixel_in = '0;
    drive(1'b1, rand_vec());
    drive(1'b1, rand_vec());
    drive(1'b0, pack4(0, -1, 200, -222));
    drive(1'b0, pack4(127, -128, 16, -168));
    drive(1'b0, pack4(255, -256, -128, 5));
    drive(1'b0, pack4(-256, 255, 64, -65));
    for (int i = 0; i < 150; i++) drive(1'b0, rand_vec());
    drive(1'b1, rand_vec());
    for (int i = 0; i < 100; i++) drive(1'b0, rand_vec());
    repeat (3) @(negedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
